cell_ram_arbiter: RTL and testbench

CELL_RAM_ARBITER -- requirements
Module: cell_ram_arbiter

---
 rtl/game_pkg.sv | 17 +
 rtl/cell_ram_arbiter_rr_pick3.sv | 32 +++
 rtl/cell_ram_arbiter.sv | 115 +++++++++++
 tb/tb_cell_ram_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the cell-grid blocks: requester indices and arbiter state.
package game_pkg;

  localparam logic [1:0] REQ_COPY = 2'd0;
  localparam logic [1:0] REQ_CNS  = 2'd1;
  localparam logic [1:0] REQ_DRAW = 2'd2;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    return 3'(3'b001 << idx);
  endfunction

endpackage

// File: rtl/cell_ram_arbiter_rr_pick3.sv
// Three-way round-robin picker: searches from last+1, so last has lowest priority.
module rr_pick3 (
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic       valid,
  output logic [1:0] idx
);

  logic [1:0] c0, c1, c2;

  // An out-of-range last (3) behaves like 2 so requester 0 is searched first.
  assign c0 = (last >= 2'd2) ? 2'd0 : 2'(last + 2'd1);
  assign c1 = (c0 == 2'd2) ? 2'd0 : 2'(c0 + 2'd1);
  assign c2 = (c1 == 2'd2) ? 2'd0 : 2'(c1 + 2'd1);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    valid = 1'b0;
    idx   = 2'd0;
    if (req[c0]) begin
      valid = 1'b1;
      idx   = c0;
    end else if (req[c1]) begin
      valid = 1'b1;
      idx   = c1;
    end else if (req[c2]) begin
      valid = 1'b1;
      idx   = c2;
    end
  end

endmodule

// File: rtl/cell_ram_arbiter.sv
// Arbitrates three cell-grid requesters onto one single-port RAM with
// round-robin ownership, burst-limited preemption and per-requester read return.
module cell_ram_arbiter
  import game_pkg::*;
#(
  parameter int ACTIVE_COLUMNS = 640,
  parameter int ACTIVE_ROWS    = 480,
  parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
  parameter int DATA_WIDTH     = 2,
  parameter int MAX_BURST      = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [2:0]              req_i,
  input  logic [2:0]              lock_i,
  input  logic [2:0]              wr_en_i,
  input  logic [3*ADDR_WIDTH-1:0] addr_i,
  input  logic [3*DATA_WIDTH-1:0] wr_data_i,
  input  logic [DATA_WIDTH-1:0]   ram_rd_data_i,
  output logic [2:0]              gnt_o,
  output logic [2:0]              rd_valid_o,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic [DATA_WIDTH-1:0]   ram_wr_data_o,
  output logic                    ram_wr_en_o
);

  localparam int               BW         = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0]    BURST_LAST = BW'(MAX_BURST - 1);

  arb_state_e    state_q;
  logic [1:0]    owner_q, last_q;
  logic [BW-1:0] burst_q;
  logic [2:0]    gnt_q, rd_valid_q;

  logic       owned, access, preempt;
  logic [1:0] pick_last, pick_idx;
  logic       pick_valid;

  assign owned   = (state_q == ARB_OWNED);
  assign access  = owned && req_i[owner_q];
  assign preempt = access && (burst_q == BURST_LAST) && !lock_i[owner_q]
                   && |(req_i & ~onehot3(owner_q));

  // While owned, search relative to the current owner so it ranks last.
  assign pick_last = owned ? owner_q : last_q;

  rr_pick3 u_pick (
    .req   (req_i),
    .last  (pick_last),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ARB_IDLE;
      owner_q    <= REQ_COPY;
      last_q     <= REQ_DRAW;
      burst_q    <= '0;
      gnt_q      <= '0;
      rd_valid_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      rd_valid_q <= (access && !wr_en_i[owner_q]) ? onehot3(owner_q) : 3'b000;
      case (state_q)
        ARB_IDLE: begin
          if (pick_valid) begin
            state_q <= ARB_OWNED;
            owner_q <= pick_idx;
            last_q  <= pick_idx;
            gnt_q   <= onehot3(pick_idx);
            burst_q <= '0;
          end
        end
        ARB_OWNED: begin
          // A drop and a preemption in the same cycle resolve identically.
          if (!req_i[owner_q] || preempt) begin
            burst_q <= '0;
            if (pick_valid) begin
              owner_q <= pick_idx;
              last_q  <= pick_idx;
              gnt_q   <= onehot3(pick_idx);
            end else begin
              state_q <= ARB_IDLE;
              gnt_q   <= '0;
            end
          end else if (burst_q != BURST_LAST) begin
            burst_q <= burst_q + 1'b1;
          end
        end
        default: begin
          state_q <= ARB_IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    ram_addr_o    = '0;
    ram_wr_data_o = '0;
    ram_wr_en_o   = 1'b0;
    if (access) begin
      ram_addr_o    = addr_i[owner_q*ADDR_WIDTH +: ADDR_WIDTH];
      ram_wr_data_o = wr_data_i[owner_q*DATA_WIDTH +: DATA_WIDTH];
      ram_wr_en_o   = wr_en_i[owner_q];
    end
  end

  assign gnt_o      = gnt_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = ram_rd_data_i;

endmodule

// File: tb/tb_cell_ram_arbiter.sv
// Directed bench for cell_ram_arbiter: a per-cycle vector table plus
// hand-written lock, preemption and mid-burst reset sequences.
module tb_cell_ram_arbiter;

  localparam int AW = 19;
  localparam int DW = 2;

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic [2:0]      req_i, lock_i, wr_en_i;
  logic [3*AW-1:0] addr_i;
  logic [3*DW-1:0] wr_data_i;
  logic [DW-1:0]   ram_rd_data_i;
  logic [2:0]      gnt_o, rd_valid_o;
  logic [DW-1:0]   rd_data_o, ram_wr_data_o;
  logic [AW-1:0]   ram_addr_o;
  logic            ram_wr_en_o;

  int tests_run    = 0;
  int tests_failed = 0;

  cell_ram_arbiter dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .req_i         (req_i),
    .lock_i        (lock_i),
    .wr_en_i       (wr_en_i),
    .addr_i        (addr_i),
    .wr_data_i     (wr_data_i),
    .ram_rd_data_i (ram_rd_data_i),
    .gnt_o         (gnt_o),
    .rd_valid_o    (rd_valid_o),
    .rd_data_o     (rd_data_o),
    .ram_addr_o    (ram_addr_o),
    .ram_wr_data_o (ram_wr_data_o),
    .ram_wr_en_o   (ram_wr_en_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0]    req, lock, wr_en;
    logic [AW-1:0] a0, a1, a2;
    logic [DW-1:0] d0, d1, d2, ram_rd;
    logic [2:0]    e_gnt, e_rdv;
    logic [AW-1:0] e_addr;
    logic          e_we;
    logic [DW-1:0] e_wd;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] req, input logic [2:0] wr_en,
                              input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                              input logic [AW-1:0] a2, input logic [DW-1:0] d0,
                              input logic [DW-1:0] d1, input logic [DW-1:0] ram_rd,
                              input logic [2:0] e_gnt, input logic [2:0] e_rdv,
                              input logic [AW-1:0] e_addr, input logic e_we,
                              input logic [DW-1:0] e_wd);
    vec_t v;
    v.req = req;  v.lock = 3'b000; v.wr_en = wr_en;
    v.a0 = a0;    v.a1 = a1;       v.a2 = a2;
    v.d0 = d0;    v.d1 = d1;       v.d2 = '0;   v.ram_rd = ram_rd;
    v.e_gnt = e_gnt; v.e_rdv = e_rdv; v.e_addr = e_addr; v.e_we = e_we; v.e_wd = e_wd;
    return v;
  endfunction

  task automatic idle_inputs();
    req_i = '0; lock_i = '0; wr_en_i = '0;
    addr_i = '0; wr_data_i = '0; ram_rd_data_i = '0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  initial begin
    //            req     wr_en   a0  a1      a2  d0     d1     ram    gnt     rdv     addr    we    wd
    vecs[0]  = mk(3'b000, 3'b000, 0,  0,      0,  2'b00, 2'b00, 2'b10, 3'b000, 3'b000, 0,      1'b0, 2'b00);
    vecs[1]  = mk(3'b100, 3'b000, 0,  0,      5,  2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0,      1'b0, 2'b00);
    vecs[2]  = mk(3'b100, 3'b000, 0,  0,      5,  2'b00, 2'b00, 2'b00, 3'b100, 3'b000, 5,      1'b0, 2'b00);
    vecs[3]  = mk(3'b000, 3'b000, 0,  0,      5,  2'b00, 2'b00, 2'b11, 3'b100, 3'b100, 0,      1'b0, 2'b00);
    vecs[4]  = mk(3'b010, 3'b010, 0,  307199, 0,  2'b00, 2'b01, 2'b00, 3'b000, 3'b000, 0,      1'b0, 2'b00);
    vecs[5]  = mk(3'b010, 3'b010, 0,  307199, 0,  2'b00, 2'b01, 2'b00, 3'b010, 3'b000, 307199, 1'b1, 2'b01);
    vecs[6]  = mk(3'b011, 3'b000, 9,  7,      0,  2'b10, 2'b00, 2'b00, 3'b010, 3'b000, 7,      1'b0, 2'b00);
    vecs[7]  = mk(3'b001, 3'b001, 9,  7,      0,  2'b10, 2'b00, 2'b00, 3'b010, 3'b010, 0,      1'b0, 2'b00);
    vecs[8]  = mk(3'b001, 3'b001, 9,  0,      0,  2'b10, 2'b00, 2'b00, 3'b001, 3'b000, 9,      1'b1, 2'b10);
    vecs[9]  = mk(3'b000, 3'b000, 0,  0,      0,  2'b00, 2'b00, 2'b00, 3'b001, 3'b000, 0,      1'b0, 2'b00);
    vecs[10] = mk(3'b000, 3'b000, 0,  0,      0,  2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0,      1'b0, 2'b00);

    // Reset-state checks while reset is held.
    reset_i = 1'b1;
    idle_inputs();
    ram_rd_data_i = 2'b01;
    #2;
    check("reset_gnt",     64'(gnt_o), 64'(3'b000));
    check("reset_rdv",     64'(rd_valid_o), 64'(3'b000));
    check("reset_we",      64'(ram_wr_en_o), 64'(1'b0));
    check("reset_addr",    64'(ram_addr_o), 64'(0));
    check("reset_rd_data", 64'(rd_data_o), 64'(2'b01));
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;

    // Table: inputs applied at negedge, outputs sampled 2 time units later.
    for (int i = 0; i < 11; i++) begin
      req_i = vecs[i].req; lock_i = vecs[i].lock; wr_en_i = vecs[i].wr_en;
      addr_i = {vecs[i].a2, vecs[i].a1, vecs[i].a0};
      wr_data_i = {vecs[i].d2, vecs[i].d1, vecs[i].d0};
      ram_rd_data_i = vecs[i].ram_rd;
      #2;
      check($sformatf("vec%0d_gnt", i),     64'(gnt_o), 64'(vecs[i].e_gnt));
      check($sformatf("vec%0d_rdv", i),     64'(rd_valid_o), 64'(vecs[i].e_rdv));
      check($sformatf("vec%0d_addr", i),    64'(ram_addr_o), 64'(vecs[i].e_addr));
      check($sformatf("vec%0d_we", i),      64'(ram_wr_en_o), 64'(vecs[i].e_we));
      check($sformatf("vec%0d_wd", i),      64'(ram_wr_data_o), 64'(vecs[i].e_wd));
      check($sformatf("vec%0d_rd_data", i), 64'(rd_data_o), 64'(vecs[i].ram_rd));
      @(negedge clk_i);
    end

    // All requesting, requester 0 locked: it wins first and holds for 20 cycles.
    do_reset();
    req_i = 3'b111; lock_i = 3'b001;
    #2 check("lock_latency", 64'(gnt_o), 64'(3'b000));
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i); #2;
      check($sformatf("lock_hold%0d", c), 64'(gnt_o), 64'(3'b001));
    end
    @(negedge clk_i);
    lock_i = 3'b000;
    #2 check("lock_still", 64'(gnt_o), 64'(3'b001));
    @(negedge clk_i); #2;
    check("unlock_preempt", 64'(gnt_o), 64'(3'b010));

    // Two requesters, no locks: 16 accesses each, then the grant rotates.
    do_reset();
    req_i = 3'b110;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk_i); #2;
      check($sformatf("burst1_%0d", c), 64'(gnt_o), 64'(3'b010));
    end
    for (int c = 0; c < 16; c++) begin
      @(negedge clk_i); #2;
      check($sformatf("burst2_%0d", c), 64'(gnt_o), 64'(3'b100));
    end
    @(negedge clk_i); #2;
    check("burst_back_to_1", 64'(gnt_o), 64'(3'b010));

    // Reset mid-burst with a read pulse pending and a write in flight.
    do_reset();
    req_i = 3'b001; wr_en_i = 3'b000; addr_i = {{AW{1'b0}}, {AW{1'b0}}, AW'(11)};
    wr_data_i = {{DW{1'b0}}, {DW{1'b0}}, 2'b01};
    @(negedge clk_i); #2;
    check("mid_gnt", 64'(gnt_o), 64'(3'b001));
    check("mid_read_addr", 64'(ram_addr_o), 64'(11));
    @(negedge clk_i);
    wr_en_i = 3'b001;
    #2;
    check("mid_rdv_pending", 64'(rd_valid_o), 64'(3'b001));
    check("mid_we", 64'(ram_wr_en_o), 64'(1'b1));
    reset_i = 1'b1;
    #1;
    check("async_gnt", 64'(gnt_o), 64'(3'b000));
    check("async_we", 64'(ram_wr_en_o), 64'(1'b0));
    check("async_addr", 64'(ram_addr_o), 64'(0));
    check("async_rdv", 64'(rd_valid_o), 64'(3'b000));
    @(negedge clk_i);
    reset_i = 1'b0;
    req_i = 3'b111; wr_en_i = 3'b000;
    #2 check("post_reset_rdv", 64'(rd_valid_o), 64'(3'b000));
    @(negedge clk_i); #2;
    check("post_reset_first", 64'(gnt_o), 64'(3'b001));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
